// File: rtl/serial_subtractor.sv
// Bit-serial LSB-first subtractor: {Bout, diff} = A - B - Bin, one bit per clock.
// Optional macro SUB_OVERFLOW_EN adds the signed-overflow output ovf.
module serial_subtractor #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             Bin,
   output logic [WIDTH-1:0] diff,
   output logic             Bout,
`ifdef SUB_OVERFLOW_EN
   output logic             ovf,
`endif
   output logic             busy,
   output logic             done
);

   localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state_reg, state_next;
   logic [WIDTH-1:0] rega_reg, regb_reg, part_reg;
   logic             br_reg;
   logic [CW-1:0]    cnt_reg;
   logic             d_bit, br_next, last_bit;

   // Full-subtractor cell on the current LSBs plus the stored borrow
   always_comb begin
      d_bit    = rega_reg[0] ^ regb_reg[0] ^ br_reg;
      br_next  = (~rega_reg[0] & regb_reg[0]) | (~(rega_reg[0] ^ regb_reg[0]) & br_reg);
      last_bit = (cnt_reg == CW'(WIDTH - 1));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      busy       = 1'b0;
      done       = 1'b0;
      case (state_reg)
         IDLE: begin
            if (start) state_next = RUN;
         end
         RUN: begin
            busy = 1'b1;
            if (last_bit) state_next = DONE;
         end
         DONE: begin
            busy       = 1'b1;
            done       = 1'b1;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // Result registers are only written on the edge that completes the MSB
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rega_reg <= '0;
         regb_reg <= '0;
         part_reg <= '0;
         br_reg   <= 1'b0;
         cnt_reg  <= '0;
         diff     <= '0;
         Bout     <= 1'b0;
`ifdef SUB_OVERFLOW_EN
         ovf      <= 1'b0;
`endif
      end else begin
         case (state_reg)
            IDLE: begin
               if (start) begin
                  rega_reg <= A;
                  regb_reg <= B;
                  br_reg   <= Bin;
                  cnt_reg  <= '0;
               end
            end
            RUN: begin
               rega_reg <= {1'b0, rega_reg[WIDTH-1:1]};
               regb_reg <= {1'b0, regb_reg[WIDTH-1:1]};
               part_reg <= {d_bit, part_reg[WIDTH-1:1]};
               br_reg   <= br_next;
               cnt_reg  <= cnt_reg + CW'(1);
               if (last_bit) begin
                  diff <= {d_bit, part_reg[WIDTH-1:1]};
                  Bout <= br_next;
`ifdef SUB_OVERFLOW_EN
                  ovf  <= br_reg ^ br_next;
`endif
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: directed and random ops at WIDTH=8,
// exhaustive at WIDTH=4, checked against plain integer arithmetic.
module tb_serial_subtractor;

   logic       clk = 1'b0;
   logic       rst8_n, start8, bin8, bout8, busy8, done8;
   logic [7:0] a8, b8, diff8;
   logic       rst4_n, start4, bin4, bout4, busy4, done4;
   logic [3:0] a4, b4, diff4;
`ifdef SUB_OVERFLOW_EN
   logic       ovf8, ovf4;
`endif

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   serial_subtractor #(.WIDTH(8)) dut8 (
      .clk(clk), .rst_n(rst8_n), .start(start8), .A(a8), .B(b8), .Bin(bin8),
      .diff(diff8), .Bout(bout8),
`ifdef SUB_OVERFLOW_EN
      .ovf(ovf8),
`endif
      .busy(busy8), .done(done8)
   );

   serial_subtractor #(.WIDTH(4)) dut4 (
      .clk(clk), .rst_n(rst4_n), .start(start4), .A(a4), .B(b4), .Bin(bin4),
      .diff(diff4), .Bout(bout4),
`ifdef SUB_OVERFLOW_EN
      .ovf(ovf4),
`endif
      .busy(busy4), .done(done4)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // One WIDTH=8 operation; scramble holds start high and changes operands mid-run
   task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic bin, input bit scramble);
      int         r, sr, lat;
      logic [7:0] exp_diff, old_diff;
      logic       exp_bout, exp_ovf, old_bout;
      r        = int'(a) - int'(b) - int'(bin);
      exp_diff = r[7:0];
      exp_bout = (r < 0);
      sr       = int'($signed(a)) - int'($signed(b)) - int'(bin);
      exp_ovf  = (sr < -128) || (sr > 127);
      old_diff = diff8;
      old_bout = bout8;
      a8 = a; b8 = b; bin8 = bin; start8 = 1'b1;
      @(posedge clk); #1;
      if (!scramble) start8 = 1'b0;
      check("busy_after_capture", busy8, 1);
      lat = 0;
      for (int k = 1; k <= 10; k++) begin
         if (scramble) begin
            a8 = 8'($urandom); b8 = 8'($urandom); bin8 = 1'($urandom);
         end
         @(posedge clk); #1;
         if (done8) begin
            lat = k;
            break;
         end
         check("diff_hold_in_run", diff8, old_diff);
         check("bout_hold_in_run", bout8, old_bout);
      end
      check("done_latency", lat, 8);
      check("diff", diff8, exp_diff);
      check("bout", bout8, exp_bout);
`ifdef SUB_OVERFLOW_EN
      check("ovf", ovf8, exp_ovf);
`endif
      @(posedge clk); #1;
      start8 = 1'b0;
      check("done_one_cycle", done8, 0);
      check("busy_back_idle", busy8, 0);
      check("diff_held_idle", diff8, exp_diff);
      $display("op8 A=%02h B=%02h Bin=%0d -> diff=%02h Bout=%0d (exp %02h %0d)%s",
               a, b, bin, diff8, bout8, exp_diff, exp_bout, scramble ? " [start held, operands changed]" : "");
   endtask

   task automatic op4(input logic [3:0] a, input logic [3:0] b, input logic bin);
      int         r, lat;
      lat = 0;
      r   = int'(a) - int'(b) - int'(bin);
      a4 = a; b4 = b; bin4 = bin; start4 = 1'b1;
      @(posedge clk); #1;
      start4 = 1'b0;
      for (int k = 1; k <= 6; k++) begin
         @(posedge clk); #1;
         if (done4) begin
            lat = k;
            break;
         end
         check("w4_busy_before_done", busy4, 1);
      end
      check("w4_latency", lat, 4);
      check("w4_result", {27'd0, bout4, diff4}, {27'd0, (r < 0), r[3:0]});
      @(posedge clk); #1;
   endtask

   initial begin
      rst8_n = 1'b0; rst4_n = 1'b0;
      start8 = 1'b0; a8 = '0; b8 = '0; bin8 = 1'b0;
      start4 = 1'b0; a4 = '0; b4 = '0; bin4 = 1'b0;
      #12;
      check("reset_diff", diff8, 0);
      check("reset_bout", bout8, 0);
      check("reset_busy", busy8, 0);
      check("reset_done", done8, 0);
      @(negedge clk);
      rst8_n = 1'b1; rst4_n = 1'b1;
      @(posedge clk); #1;

      op8(8'h05, 8'h03, 1'b0, 1'b0);
      op8(8'h03, 8'h05, 1'b0, 1'b0);
      op8(8'h00, 8'h00, 1'b1, 1'b0);
      op8(8'h80, 8'h01, 1'b0, 1'b0);
      op8(8'hA7, 8'h3C, 1'b1, 1'b1);
      op8(8'h12, 8'h34, 1'b0, 1'b0);

      // Abort mid-operation with a nonzero result already held
      a8 = 8'h55; b8 = 8'h11; bin8 = 1'b0; start8 = 1'b1;
      @(posedge clk); #1;
      start8 = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      rst8_n = 1'b0;
      #1;
      check("abort_diff", diff8, 0);
      check("abort_bout", bout8, 0);
      check("abort_busy", busy8, 0);
      check("abort_done", done8, 0);
      for (int k = 0; k < 3; k++) begin
         @(posedge clk); #1;
         check("abort_no_done", done8, 0);
      end
      @(negedge clk);
      rst8_n = 1'b1;
      @(posedge clk); #1;
      op8(8'hC3, 8'h5A, 1'b1, 1'b0);

      for (int i = 0; i < 30; i++)
         op8(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom_range(0, 3) == 0));

      for (int a = 0; a < 16; a++)
         for (int b = 0; b < 16; b++)
            for (int c = 0; c < 2; c++)
               op4(4'(a), 4'(b), 1'(c));
      $display("exhaustive WIDTH=4 sweep done (512 ops)");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
